// File: rtl/points_scorer.sv
// points_scorer: snapshots N_CH led/btn pairs on start, compares one channel
// per cycle, then reports hit/miss, a match count and a saturating score.
module points_scorer #(
  parameter  int N_CH        = 3,
  parameter  int SCORE_W     = 8,
  parameter  int PTS_PER_HIT = 1,
  parameter  int MODE        = 0,
  localparam int MC_W        = $clog2(N_CH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_CH-1:0]    led,
  input  logic [N_CH-1:0]    btn,
  input  logic               score_clr,
  output logic               busy,
  output logic               done,
  output logic               hit,
  output logic [MC_W-1:0]    match_cnt,
  output logic               pf_out,
  output logic [SCORE_W-1:0] score
);

  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {IDLE, CHECK} state_t;

  state_t            state, state_nxt;
  logic [N_CH-1:0]   snap_led, snap_btn;
  logic [IW-1:0]     idx;
  logic [MC_W-1:0]   cnt;
  logic [MC_W-1:0]   cnt_nxt;
  logic              last;
  logic              hit_nxt;
  logic [SCORE_W:0]  sum;

  // The snapshot is shifted right each CHECK cycle, so bit 0 is always the
  // channel currently being compared; idx only tracks when to stop.
  assign last    = (idx == IW'(N_CH - 1));
  assign cnt_nxt = cnt + MC_W'(snap_led[0] == snap_btn[0]);
  assign hit_nxt = (MODE == 0) ? (cnt_nxt != '0) : (cnt_nxt == MC_W'(N_CH));
  assign sum     = {1'b0, score} + (SCORE_W+1)'(PTS_PER_HIT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> CHECK on start, back after the last channel.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round datapath: snapshot, per-channel accumulate, result and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_led  <= '0;
      snap_btn  <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pf_out    <= 1'b0;
      hit       <= 1'b0;
      match_cnt <= '0;
    end else begin
      done   <= 1'b0;
      pf_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_led <= led;
            snap_btn <= btn;
            idx      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end
        CHECK: begin
          snap_led <= snap_led >> 1;
          snap_btn <= snap_btn >> 1;
          cnt      <= cnt_nxt;
          idx      <= idx + IW'(1);
          if (last) begin
            idx       <= '0;
            match_cnt <= cnt_nxt;
            hit       <= hit_nxt;
            done      <= 1'b1;
            pf_out    <= hit_nxt;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating score; a clear beats a simultaneous hit update.
  always_ff @(posedge clk) begin
    if (rst)
      score <= '0;
    else if (score_clr)
      score <= '0;
    else if (state == CHECK && last && hit_nxt)
      score <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

endmodule

// File: tb/tb_points_scorer.sv
// Bench for points_scorer: two instances (ANY/8-bit/+1 and ALL/4-bit/+3)
// share stimulus; a round-level reference model feeds per-DUT scoreboards.
module tb_points_scorer;

  logic       clk = 1'b0;
  logic       rst, start, score_clr;
  logic [2:0] led, btn;

  logic       busy0, done0, hit0, pf0;
  logic [1:0] mc0;
  logic [7:0] score0;
  logic       busy1, done1, hit1, pf1;
  logic [1:0] mc1;
  logic [3:0] score1;

  always #5 clk = ~clk;

  points_scorer #(.N_CH(3), .SCORE_W(8), .PTS_PER_HIT(1), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .led(led), .btn(btn), .score_clr(score_clr),
    .busy(busy0), .done(done0), .hit(hit0), .match_cnt(mc0), .pf_out(pf0), .score(score0));

  points_scorer #(.N_CH(3), .SCORE_W(4), .PTS_PER_HIT(3), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .led(led), .btn(btn), .score_clr(score_clr),
    .busy(busy1), .done(done1), .hit(hit1), .match_cnt(mc1), .pf_out(pf1), .score(score1));

  typedef struct {int cyc; int mc; bit h; int sc;} exp_t;
  exp_t q0[$], q1[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit chk_en = 0;

  // model configuration and state, one slot per DUT
  int mode_k [2] = '{0, 1};
  int max_k  [2] = '{255, 15};
  int pts_k  [2] = '{1, 3};
  int m_left [2] = '{0, 0};
  int m_score[2] = '{0, 0};
  int m_mc   [2] = '{0, 0};
  bit m_hit  [2] = '{0, 0};
  logic [2:0] m_sl[2], m_sb[2];
  // model view of the current cycle, read by the monitor
  bit cur_busy[2]; int cur_score[2]; bit cur_hit[2]; int cur_mc[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int k, input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %0d want %0d (cycle %0d)", k, name, act, expv, cyc);
    end
  endtask

  // Effect of the coming clock edge on the round model of DUT k.
  task automatic model_edge(input int k, input bit s, input logic [2:0] l, b,
                            input bit c, input bit r);
    int ns, m; bit h, fin;
    exp_t e;
    if (r) begin
      m_left[k] = 0; m_score[k] = 0; m_hit[k] = 0; m_mc[k] = 0;
      return;
    end
    ns = m_score[k]; fin = 0; m = 0; h = 0;
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        for (int i = 0; i < 3; i++) if (m_sl[k][i] == m_sb[k][i]) m++;
        h = (mode_k[k] == 0) ? (m != 0) : (m == 3);
        if (h) ns = (m_score[k] + pts_k[k] > max_k[k]) ? max_k[k] : m_score[k] + pts_k[k];
        m_hit[k] = h; m_mc[k] = m; fin = 1;
      end
    end else if (s) begin
      m_sl[k] = l; m_sb[k] = b; m_left[k] = 3;
    end
    if (c) ns = 0;
    m_score[k] = ns;
    if (fin) begin
      e.cyc = cyc + 1; e.mc = m; e.h = h; e.sc = ns;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic step(input bit s, input logic [2:0] l, b, input bit c, input bit r);
    start = s; led = l; btn = b; score_clr = c; rst = r;
    for (int k = 0; k < 2; k++) begin
      cur_busy[k] = (m_left[k] > 0); cur_score[k] = m_score[k];
      cur_hit[k] = m_hit[k]; cur_mc[k] = m_mc[k];
      model_edge(k, s, l, b, c, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'b000, 3'b000, 0, 0);
  endtask

  task automatic mon(input int k, input logic d, input logic pf, input logic h,
                     input logic [1:0] mc, input logic b, input logic [7:0] sc);
    exp_t e; bit have;
    have = 0;
    if (k == 0) begin
      if (q0.size() > 0 && (d || q0[0].cyc <= cyc)) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() > 0 && (d || q1[0].cyc <= cyc)) begin e = q1.pop_front(); have = 1; end
    end
    if (d || have) begin
      chk(k, "done", int'(d), int'(have));
      if (d && have) begin
        chk(k, "done_cycle", cyc, e.cyc);
        chk(k, "round_match_cnt", int'(mc), e.mc);
        chk(k, "round_hit", int'(h), int'(e.h));
        chk(k, "pf_out", int'(pf), int'(e.h));
        chk(k, "round_score", int'(sc), e.sc);
      end
    end else begin
      chk(k, "pf_idle", int'(pf), 0);
    end
    chk(k, "busy", int'(b), int'(cur_busy[k]));
    chk(k, "score", int'(sc), cur_score[k]);
    chk(k, "hit_held", int'(h), int'(cur_hit[k]));
    chk(k, "match_cnt_held", int'(mc), cur_mc[k]);
  endtask

  // Monitor: samples both DUTs mid-cycle and checks against the scoreboards.
  always @(negedge clk) begin
    if (chk_en) begin
      mon(0, done0, pf0, hit0, mc0, busy0, score0);
      mon(1, done1, pf1, hit1, mc1, busy1, {4'b0000, score1});
    end
  end

  initial begin
    logic [2:0] l, b;
    int guard;
    rst = 1; start = 0; led = 0; btn = 0; score_clr = 0;
    @(posedge clk); #1;
    step(0, 3'b000, 3'b000, 0, 1);
    step(0, 3'b000, 3'b000, 0, 1);
    chk_en = 1;
    idle(2);

    // full match round, then partial match (ANY hits, ALL misses)
    step(1, 3'b101, 3'b101, 0, 0); idle(5);
    step(1, 3'b101, 3'b100, 0, 0); idle(5);

    // saturation: clear, then seven back-to-back hit rounds
    step(0, 3'b000, 3'b000, 1, 0);
    for (int i = 0; i < 28; i++) step(1, 3'b111, 3'b111, 0, 0);
    idle(4);

    // clear coinciding with a hit done
    step(1, 3'b111, 3'b111, 0, 0);
    guard = 0;
    while (m_left[0] != 1 && guard < 10) begin idle(1); guard++; end
    step(0, 3'b000, 3'b000, 1, 0);
    idle(3);

    // input changes and extra start during CHECK are ignored
    step(1, 3'b101, 3'b010, 0, 0);
    step(1, 3'b101, 3'b111, 0, 0);
    step(0, 3'b101, 3'b111, 0, 0);
    idle(4);

    // reset in cycle 2 of a round, then a normal round
    step(1, 3'b011, 3'b011, 0, 0);
    idle(1);
    step(0, 3'b000, 3'b000, 0, 1);
    idle(2);
    step(1, 3'b011, 3'b011, 0, 0); idle(5);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      l = 3'($urandom);
      b = ($urandom_range(0, 1) == 1) ? l : 3'($urandom);
      step($urandom_range(0, 2) == 0, l, b, $urandom_range(0, 19) == 0,
           $urandom_range(0, 59) == 0);
    end

    // reset after random activity
    step(1, 3'b111, 3'b111, 0, 1);
    step(0, 3'b000, 3'b000, 0, 1);
    idle(6);

    chk(0, "pending_dones", q0.size(), 0);
    chk(1, "pending_dones", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
